// File: rtl/serial_addsub_pkg.sv
// Shared types for the serial add/subtract engine.
// Holds the FSM state encoding and the default geometry (limb width and count).
package serial_addsub_pkg;

  localparam int unsigned DefLimbW = 32;
  localparam int unsigned DefLimbs = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/response bundle for serial_addsub.
// slave  : engine side (takes start/add_sub/a/b, drives busy/done/result/cout)
// master : requester side
interface serial_addsub_if #(
  parameter int unsigned LIMB_W = 32,
  parameter int unsigned LIMBS  = 8
);
  localparam int unsigned W = LIMB_W * LIMBS;

  logic         start_i;
  logic         add_sub_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         cout_o;

  modport slave (
    input  start_i, add_sub_i, a_i, b_i,
    output busy_o, done_o, result_o, cout_o
  );

  modport master (
    output start_i, add_sub_i, a_i, b_i,
    input  busy_o, done_o, result_o, cout_o
  );
endinterface

// File: rtl/serial_addsub_pmi_addsub.sv
// Behavioural model of the vendor pmi_addsub slice (port names follow the macro so the
// vendor primitive can be dropped in unchanged).
// DataA/DataB : operands        Cin     : carry in (subtract: 1 = no borrow in)
// Add_Sub     : 1 add, 0 sub    Result  : sum/difference
// Cout        : carry out (subtract: 1 = no borrow out)
module pmi_addsub #(
  parameter int pmi_data_width   = 8,
  parameter int pmi_result_width = 8
) (
  input  logic [pmi_data_width-1:0]   DataA,
  input  logic [pmi_data_width-1:0]   DataB,
  input  logic                        Cin,
  input  logic                        Add_Sub,
  output logic [pmi_result_width-1:0] Result,
  output logic                        Cout
);
  logic [pmi_data_width-1:0] b_eff;
  logic [pmi_data_width:0]   sum;

  // Subtract as A + ~B + Cin, so Cout is the no-borrow flag with no extra logic.
  always_comb begin
    b_eff = Add_Sub ? DataB : ~DataB;
    sum   = {1'b0, DataA} + {1'b0, b_eff} + {{pmi_data_width{1'b0}}, Cin};
  end

  assign Result = sum[pmi_result_width-1:0];
  assign Cout   = sum[pmi_data_width];
endmodule

// File: rtl/serial_addsub.sv
// Wide add/subtract engine: streams LIMBS x LIMB_W operands through one LIMB_W-bit
// adder slice, least-significant limb first, chaining carry/borrow between limbs.
// CLK_I : clock (rising edge)      RST_I : synchronous active-high reset
// bus   : request (start, add_sub, a, b) and response (busy, done, result, cout)
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned LIMB_W = DefLimbW,
  parameter int unsigned LIMBS  = DefLimbs
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  serial_addsub_if.slave  bus
);
  localparam int unsigned IdxW = $clog2(LIMBS);
  typedef logic [IdxW-1:0] idx_t;
  typedef logic [LIMBS-1:0][LIMB_W-1:0] word_t;

  state_e state_q, state_d;
  idx_t   idx_q, idx_d;
  logic   carry_q, carry_d;
  logic   add_q, add_d;
  logic   cout_q, cout_d;
  word_t  a_q, a_d, b_q, b_d, res_q, res_d;

  logic [LIMB_W-1:0] limb_sum;
  logic              limb_cout;

  pmi_addsub #(
    .pmi_data_width   (LIMB_W),
    .pmi_result_width (LIMB_W)
  ) u_slice (
    .DataA   (a_q[idx_q]),
    .DataB   (b_q[idx_q]),
    .Cin     (carry_q),
    .Add_Sub (add_q),
    .Result  (limb_sum),
    .Cout    (limb_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    add_d   = add_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          add_d   = bus.add_sub_i;
          idx_d   = '0;
          // Subtract starts with "no borrow" asserted.
          carry_d = ~bus.add_sub_i;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d[idx_q] = limb_sum;
        carry_d      = limb_cout;
        idx_d        = idx_q + idx_t'(1);
        if (idx_q == idx_t'(LIMBS - 1)) begin
          idx_d   = '0;
          cout_d  = limb_cout;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      add_q   <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      add_q   <= add_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy_o   = (state_q != StIdle);
  assign bus.done_o   = (state_q == StDone);
  assign bus.result_o = res_q;
  assign bus.cout_o   = cout_q;
endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
  localparam int unsigned LimbW = 32;
  localparam int unsigned Limbs = 8;
  localparam int unsigned W     = LimbW * Limbs;

  typedef struct {
    string        name;
    logic         add_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_cout;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_addsub_if #(.LIMB_W(LimbW), .LIMBS(Limbs)) bus ();

  serial_addsub #(.LIMB_W(LimbW), .LIMBS(Limbs)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle, so sampling happens away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < int'(Limbs); i++) v[i*LimbW +: LimbW] = $urandom;
    return v;
  endfunction

  // Accepts one op from IDLE, checks done latency and response, returns to IDLE.
  task automatic run_op(input vec_t v);
    int n;
    bus.start_i   = 1'b1;
    bus.add_sub_i = v.add_sub;
    bus.a_i       = v.a;
    bus.b_i       = v.b;
    tick();
    bus.start_i = 1'b0;
    bus.a_i     = ~v.a;
    bus.b_i     = ~v.b;
    chk({v.name, " busy"}, W'(bus.busy_o), W'(1));
    n = 0;
    while (bus.done_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    // done_o sits in the cycle after edge e_LIMBS.
    chk({v.name, " latency"}, W'(n), W'(Limbs));
    chk({v.name, " result"}, bus.result_o, v.exp_res);
    chk({v.name, " cout"}, W'(bus.cout_o), W'(v.exp_cout));
    tick();
    chk({v.name, " done_clr"}, W'({bus.done_o, bus.busy_o}), W'(0));
  endtask

  vec_t vecs[7];

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] top;
    logic [W-1:0] pat;
    int           dones;

    checks = 0;
    errors = 0;
    ones = {W{1'b1}};
    top  = {1'b1, {(W-1){1'b0}}};
    pat  = {8{32'h12345678}};

    vecs[0] = '{"add_ripple", 1'b1, ones, W'(1), '0, 1'b1};
    vecs[1] = '{"sub_limb_borrow", 1'b0, W'(64'h1_0000_0000), W'(1), W'(32'hFFFF_FFFF), 1'b1};
    vecs[2] = '{"sub_wrap", 1'b0, '0, W'(1), ones, 1'b0};
    vecs[3] = '{"sub_equal", 1'b0, pat, pat, '0, 1'b1};
    vecs[4] = '{"add_top", 1'b1, top, top, '0, 1'b1};
    vecs[5] = '{"add_small", 1'b1, W'(5), W'(7), W'(12), 1'b0};
    vecs[6] = '{"add_mid", 1'b1, {128'h0, {128{1'b1}}}, W'(1), {127'h0, 1'b1, 128'h0}, 1'b0};

    rst = 1'b1;
    bus.start_i   = 1'b0;
    bus.add_sub_i = 1'b0;
    bus.a_i       = '0;
    bus.b_i       = '0;
    tick();
    tick();
    chk("reset busy", W'(bus.busy_o), W'(0));
    chk("reset done", W'(bus.done_o), W'(0));
    chk("reset result", bus.result_o, '0);
    chk("reset cout", W'(bus.cout_o), W'(0));

    // Reset together with start: nothing accepted.
    bus.start_i = 1'b1;
    bus.a_i     = ones;
    tick();
    rst = 1'b0;
    bus.start_i = 1'b0;
    tick();
    chk("rst_start busy", W'(bus.busy_o), W'(0));

    foreach (vecs[i]) run_op(vecs[i]);

    // Busy rejection: extra start pulses at edges 3 and 9 after accept are ignored.
    bus.start_i   = 1'b1;
    bus.add_sub_i = 1'b1;
    bus.a_i       = W'(5);
    bus.b_i       = W'(7);
    tick();
    dones = 0;
    for (int e = 1; e <= 14; e++) begin
      bus.start_i   = (e == 3 || e == 9);
      bus.add_sub_i = 1'b0;
      bus.a_i       = ones;
      bus.b_i       = W'(3);
      tick();
      if (bus.done_o === 1'b1) begin
        dones++;
        chk("reject result", bus.result_o, W'(12));
      end
    end
    chk("reject done count", W'(dones), W'(1));
    chk("reject idle", W'(bus.busy_o), W'(0));

    // Reset mid-op: abort at edge 4 after accept.
    bus.start_i   = 1'b1;
    bus.add_sub_i = 1'b1;
    bus.a_i       = ones;
    bus.b_i       = ones;
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", W'(bus.busy_o), W'(0));
    chk("abort result", bus.result_o, '0);
    dones = 0;
    for (int e = 0; e < 12; e++) begin
      if (bus.done_o === 1'b1) dones++;
      tick();
    end
    chk("abort no done", W'(dones), W'(0));
    run_op(vecs[5]);

    // Back-to-back with start held high: accept, junk inputs during the op, one idle cycle.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         op;
      logic [W:0]   m;
      int           n;
      a  = rand_word();
      b  = rand_word();
      op = 1'($urandom);
      if (i % 50 == 0) b = a;
      m = op ? ({1'b0, a} + {1'b0, b}) : {(a >= b), a - b};
      chk("b2b idle", W'(bus.busy_o), W'(0));
      bus.start_i   = 1'b1;
      bus.add_sub_i = op;
      bus.a_i       = a;
      bus.b_i       = b;
      tick();
      bus.add_sub_i = ~op;
      bus.a_i       = rand_word();
      bus.b_i       = rand_word();
      n = 0;
      while (bus.done_o !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("b2b latency", W'(n), W'(Limbs));
      chk("b2b result", bus.result_o, m[W-1:0]);
      chk("b2b cout", W'(bus.cout_o), W'(m[W]));
      tick();
    end
    bus.start_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
